// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: frame-aligned RGB duty sequencer (ramp or instant jump) feeding three pwm_driver duty inputs.
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready handshake with cmd_r/g/b targets and cmd_instant;
// duty_r/g/b to the PWM drivers; busy while a command is in flight; done pulses in the completing frame_tick
// cycle; frame_tick marks the last clock of each 256-clock PWM frame.
// Optional: define RGB_FADE_RETARGET_EN to accept new targets while fading.
module rgb_fade_ctrl #(
  parameter int STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_r,
  input  logic [7:0] cmd_g,
  input  logic [7:0] cmd_b,
  input  logic       cmd_instant,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done,
  output logic       frame_tick
);
  typedef enum logic [1:0] {IDLE, FADE, JUMP} state_t;
  state_t state;
  logic [7:0] fc, sc, tr, tg, tb, nr, ng, nb;
  logic accept, eq_now, eq_next, last_step, complete;
  function automatic logic [7:0] step(input logic [7:0] d, input logic [7:0] t);
    return d < t ? d + 8'd1 : d > t ? d - 8'd1 : d;
  endfunction
  assign nr = step(duty_r, tr);
  assign ng = step(duty_g, tg);
  assign nb = step(duty_b, tb);
  assign eq_now = {duty_r, duty_g, duty_b} == {tr, tg, tb};
  assign eq_next = {nr, ng, nb} == {tr, tg, tb};
  assign last_step = sc == 8'(STEP_FRAMES - 1);
  assign frame_tick = fc == 8'hff;
  assign busy = state != IDLE;
`ifdef RGB_FADE_RETARGET_EN
  assign cmd_ready = state != JUMP;
`else
  assign cmd_ready = state == IDLE;
`endif
  assign accept = cmd_valid & cmd_ready;
  assign complete = frame_tick & (state == JUMP | (state == FADE & (eq_now | (last_step & eq_next))));
  // a simultaneous accept supersedes the completing command, so its done is dropped
  assign done = complete & ~accept & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fc <= '0;
      sc <= '0;
      {tr, tg, tb} <= '0;
      {duty_r, duty_g, duty_b} <= '0;
    end else begin
      fc <= fc + 8'd1;
      if (accept) begin
        {tr, tg, tb} <= {cmd_r, cmd_g, cmd_b};
        sc <= '0;
        state <= cmd_instant ? JUMP : FADE;
      end else if (frame_tick && state == JUMP) begin
        {duty_r, duty_g, duty_b} <= {tr, tg, tb};
        state <= IDLE;
      end else if (frame_tick && state == FADE) begin
        if (eq_now) state <= IDLE;
        else if (last_step) begin
          sc <= '0;
          {duty_r, duty_g, duty_b} <= {nr, ng, nb};
          if (eq_next) state <= IDLE;
        end else sc <= sc + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl: directed checks of rgb_fade_ctrl with STEP_FRAMES=1 (u1) and STEP_FRAMES=2 (u2).
module tb_rgb_fade_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] cr = 0, cg = 0, cb = 0;
  logic ci = 0;
  logic val[2], rdy[2], busy[2], done[2], ft[2];
  logic [7:0] dr[2], dg[2], db[2];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  rgb_fade_ctrl #(.STEP_FRAMES(1)) u1 (.clk(clk), .rst(rst), .cmd_valid(val[0]), .cmd_ready(rdy[0]),
    .cmd_r(cr), .cmd_g(cg), .cmd_b(cb), .cmd_instant(ci), .duty_r(dr[0]), .duty_g(dg[0]), .duty_b(db[0]),
    .busy(busy[0]), .done(done[0]), .frame_tick(ft[0]));
  rgb_fade_ctrl #(.STEP_FRAMES(2)) u2 (.clk(clk), .rst(rst), .cmd_valid(val[1]), .cmd_ready(rdy[1]),
    .cmd_r(cr), .cmd_g(cg), .cmd_b(cb), .cmd_instant(ci), .duty_r(dr[1]), .duty_g(dg[1]), .duty_b(db[1]),
    .busy(busy[1]), .done(done[1]), .frame_tick(ft[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_duty(input string tag, input int s, input int r, input int g, input int b);
    chk({tag, "_r"}, 32'(dr[s]), r);
    chk({tag, "_g"}, 32'(dg[s]), g);
    chk({tag, "_b"}, 32'(db[s]), b);
  endtask
  task automatic send(input int s, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic inst);
    {cr, cg, cb, ci} = {r, g, b, inst};
    val[s] = 1;
    chk("send_ready", 32'(rdy[s]), 1);
    @(negedge clk);
    val[s] = 0;
    chk("send_busy", 32'(busy[s]), 1);
  endtask
  task automatic wait_tick(input int s);
    int n = 0;
    while (!ft[s] && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 32'(ft[s]), 1);
  endtask
  initial begin
    val[0] = 0;
    val[1] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(rdy[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk_duty("rst", 0, 0, 0, 0);
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (i == 254) chk("ft_254", 32'(ft[0]), 0);
      if (i == 255) chk("ft_255", 32'(ft[0]), 1);
      if (i == 256) chk("ft_256", 32'(ft[0]), 0);
      if (i == 511) chk("ft_511", 32'(ft[0]), 1);
    end
    chk_duty("idle", 0, 0, 0, 0);
    chk("idle_busy", 32'(busy[0]), 0);
    send(0, 10, 0, 5, 0);
    chk("fade_ready", 32'(rdy[0]), 0);
    for (int k = 1; k <= 10; k++) begin
      wait_tick(0);
      chk("ramp_done", 32'(done[0]), 32'(k == 10));
      @(negedge clk);
      chk_duty("ramp", 0, k, 0, k < 5 ? k : 5);
    end
    chk("ramp_busy_fall", 32'(busy[0]), 0);
    chk("ramp_ready", 32'(rdy[0]), 1);
    send(0, 255, 128, 64, 1);
    wait_tick(0);
    chk("jump_done", 32'(done[0]), 1);
    chk_duty("jump_pre", 0, 10, 0, 5);
    @(negedge clk);
    chk_duty("jump", 0, 255, 128, 64);
    chk("jump_done_end", 32'(done[0]), 0);
    chk("jump_busy", 32'(busy[0]), 0);
    send(0, 255, 128, 64, 0);
    wait_tick(0);
    chk("same_done", 32'(done[0]), 1);
    @(negedge clk);
    chk_duty("same", 0, 255, 128, 64);
    chk("same_busy", 32'(busy[0]), 0);
`ifndef RGB_FADE_RETARGET_EN
    send(0, 250, 128, 64, 0);
    {cr, cg, cb, ci} = {8'd0, 8'd0, 8'd0, 1'b1};
    val[0] = 1;
    for (int k = 1; k <= 5; k++) begin
      chk("hold_ready", 32'(rdy[0]), 0);
      wait_tick(0);
      chk("hold_tick_ready", 32'(rdy[0]), 0);
      chk("hold_done", 32'(done[0]), 32'(k == 5));
      @(negedge clk);
      chk("hold_r", 32'(dr[0]), 255 - k);
    end
    chk("hold_ready_idle", 32'(rdy[0]), 1);
    @(negedge clk);
    val[0] = 0;
    chk("hold_accept_busy", 32'(busy[0]), 1);
    wait_tick(0);
    @(negedge clk);
    chk_duty("hold_jump", 0, 0, 0, 0);
`else
    send(0, 250, 128, 64, 0);
    wait_tick(0);
    chk("rt_done0", 32'(done[0]), 0);
    @(negedge clk);
    chk("rt_r", 32'(dr[0]), 254);
    chk("rt_ready_fade", 32'(rdy[0]), 1);
    send(0, 255, 128, 64, 0);
    wait_tick(0);
    chk("rt_done", 32'(done[0]), 1);
    @(negedge clk);
    chk_duty("rt", 0, 255, 128, 64);
    chk("rt_busy", 32'(busy[0]), 0);
`endif
    send(1, 3, 3, 3, 0);
    for (int k = 1; k <= 6; k++) begin
      wait_tick(1);
      chk("up2_done", 32'(done[1]), 32'(k == 6));
      @(negedge clk);
    end
    chk_duty("up2", 1, 3, 3, 3);
    send(1, 1, 3, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      wait_tick(1);
      chk("dn2_done", 32'(done[1]), 32'(k == 6));
      @(negedge clk);
      chk_duty("dn2", 1, k < 2 ? 3 : k < 4 ? 2 : 1, 3, k < 2 ? 3 : k < 4 ? 2 : k < 6 ? 1 : 0);
    end
    chk("dn2_busy", 32'(busy[1]), 0);
    send(0, 7, 7, 7, 1);
    wait_tick(0);
    @(negedge clk);
    chk_duty("pre_rst", 0, 7, 7, 7);
    send(0, 20, 20, 20, 0);
    rst = 1;
    chk("rst_mid_done", 32'(done[0]), 0);
    @(negedge clk);
    chk_duty("rst_mid", 0, 0, 0, 0);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    chk("rst_mid_ready", 32'(rdy[0]), 1);
    rst = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (i == 254) chk("re_ft_254", 32'(ft[0]), 0);
      if (i == 255) chk("re_ft_255", 32'(ft[0]), 1);
    end
    chk("re_done", 32'(done[0]), 0);
    chk_duty("re_idle", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
Sequencer that drives the duty_cycle inputs of three pwm_driver instances (R, G, B) in the RGB mixer.
- Accepts a target colour over a valid/ready command interface.
- Ramps each channel's duty toward its target by ±1 per step, or jumps to the target when instant mode is requested.
- Changes duty values only at PWM frame boundaries (every 256 clocks), so no glitched PWM periods occur.

Parameters:
STEP_FRAMES, 4, PWM frames per ramp step; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_r  input  8  target red duty
cmd_g  input  8  target green duty
cmd_b  input  8  target blue duty
cmd_instant  input  1  1 = jump to target at next frame boundary, 0 = ramp
duty_r  output  8  to red pwm_driver duty_cycle
duty_g  output  8  to green pwm_driver duty_cycle
duty_b  output  8  to blue pwm_driver duty_cycle
busy  output  1  fade or jump in progress
done  output  1  one-cycle pulse when outputs reach target
frame_tick  output  1  high for the last clock of each 256-clock PWM frame

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst.
- Reset values:
  - duty_r/g/b = 0, busy = 0, done = 0, state = IDLE.
  - Frame counter = 0, step counter = 0, targets = 0.
  - cmd_ready = 1 in the first cycle after rst deasserts.
- Frame counter:
  - 8-bit, free-running, wraps 255 -> 0.
  - frame_tick = (frame counter == 255), combinational from the register.
  - First tick is 255 clocks after rst deasserts.
  - Aligned with pwm_driver frames because both share clk/rst.
- All duty_* updates happen on the clock edge that ends a frame_tick cycle, so new values are valid from frame counter 0.
- States:
  - IDLE: cmd_ready = 1, busy = 0.
  - FADE: cmd_ready = 0, busy = 1.
  - JUMP: cmd_ready = 0, busy = 1.
- Accept rule: cmd_valid & cmd_ready at a rising edge.
  - Latch cmd_r/g/b as targets and clear the step counter.
  - Go to JUMP if cmd_instant = 1, else FADE.
  - busy rises the next cycle.
  - cmd_* are ignored while cmd_ready = 0.
- JUMP: on the next frame_tick, duty_* <= targets, done = 1 for that cycle, return to IDLE.
- FADE, on each frame_tick, in priority order:
  1. If duty_* == targets on all channels: done = 1, go to IDLE, no change. This also covers a command equal to the current colour, which completes at the first tick.
  2. Else if step counter == STEP_FRAMES-1: step counter <= 0. Each channel with duty < target increments by 1; each with duty > target decrements by 1; equal channels hold. If all channels equal targets after the step, assert done in the same cycle and go to IDLE.
  3. Else: step counter += 1.
- Duty arithmetic:
  - Channels step independently.
  - Never overshoot; no wrap (0 never decrements, 255 never increments, by construction).
- Ramp timing: worst-case full ramp (0 -> 255) = 255 steps × STEP_FRAMES × 256 clocks.
- done is high only in the frame_tick cycle where completion occurs; it is never high together with cmd_ready in the same cycle.
- rst mid-operation:
  - Abandons the command immediately; all state returns to reset values.
  - duty_* = 0 on the next cycle (not frame-aligned; reset overrides).
  - No done pulse.

Optional Feature:
Macro RGB_FADE_RETARGET_EN.
- Defined:
  - cmd_ready = 1 in IDLE and in FADE.
  - An accept in FADE replaces the targets, clears the step counter, and keeps the current duty_* values (the fade continues from the present colour).
  - Takes state JUMP if cmd_instant = 1.
  - No done pulse for the superseded command.
  - In a cycle where frame_tick completion and an accept coincide, the accept wins and done is suppressed.
  - JUMP still holds cmd_ready = 0.
- Not defined: cmd_ready = 0 in FADE and JUMP, exactly as in Behaviour.

Test Plan:
1. Reset, then idle for 600 clocks -> duty_* = 0, busy = 0, cmd_ready = 1, frame_tick pulses at clocks 255 and 511 after reset release.
2. STEP_FRAMES=1; ramp cmd (10,0,5) from 0 -> duty_r increments once per frame; duty_b stops at 5 after 5 frames; done pulses at the 10th tick after accept; busy falls next cycle.
3. Instant cmd (255,128,64) -> all duty_* change at the first frame_tick after accept (frame counter 0 thereafter); done is in that same cycle.
4. Ramp (0,0,0) -> (3,3,3), then ramp down to (1,3,0) with STEP_FRAMES=2 -> decrements every 2nd tick; duty_g holds at 3; completes after 6 frames.
5. Command equal to the current colour -> done at the first frame_tick; duty_* unchanged. cmd_valid held during FADE (macro off) -> cmd_ready = 0 and the second command is not accepted until IDLE.
6. rst asserted mid-fade at duty (7,7,7) -> duty_* = 0 the next cycle, no done pulse; the frame counter restarts. With RGB_FADE_RETARGET_EN, a retarget during FADE continues from the present duty toward the new target.
